mouse_master_sm: RTL and testbench
==================================

Name: mouse_master_sm

Overview:
PS/2 mouse bring-up and streaming controller. It sits between the host-to-mouse transmitter and the mouse receiver.
- Init sequence: sends Reset (0xFF), checks ACK (0xFA), self-test pass (0xAA) and ID (0x00), then sends Enable Data Reporting (0xF4) and checks ACK.
- Streaming: assembles 3-byte movement packets and publishes status/DX/DY with a one-cycle interrupt.
- Gates the receiver's READ_ENABLE and recovers from errors and timeouts.

Parameters:
RESP_TIMEOUT, 50000000, cycles to wait for any single init response or transmit completion (0.5 s at 100 MHz); counter width is $clog2(RESP_TIMEOUT+1).
PKT_TIMEOUT, 100000, maximum cycles between bytes 2/3 of a packet (1 ms at 100 MHz).

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
SEND_BYTE  out  1  one-cycle request to transmitter
BYTE_TO_SEND  out  8  command byte; held stable until BYTE_SENT
BYTE_SENT  in  1  one-cycle pulse from transmitter: byte transmitted and acknowledged
READ_ENABLE  out  1  enables receiver start-bit detection
BYTE_READ  in  8  received byte
BYTE_ERROR_CODE  in  2  bit0 parity error, bit1 stop-bit error; valid with BYTE_READY
BYTE_READY  in  1  one-cycle pulse, received byte valid
MOUSE_STATUS  out  8  packet byte 1 (buttons, sign, overflow)
MOUSE_DX  out  8  packet byte 2
MOUSE_DY  out  8  packet byte 3
SEND_INTERRUPT  out  1  one-cycle pulse: new packet on MOUSE_*
MASTER_STATE  out  4  current state encoding (debug)

Behaviour:
- Reset: all outputs 0, state IDLE, timer 0. Reset mid-operation aborts any exchange; the restart re-sends 0xFF.
- States and encodings:
  - IDLE 0: next cycle -> SEND_RST.
  - SEND_RST 1: SEND_BYTE=1 for exactly one cycle, BYTE_TO_SEND=0xFF -> WAIT_TX_RST.
  - WAIT_TX_RST 2: BYTE_SENT -> WAIT_ACK_RST.
  - WAIT_ACK_RST 3: expect 0xFA -> WAIT_SELFTEST.
  - WAIT_SELFTEST 4: expect 0xAA -> WAIT_ID.
  - WAIT_ID 5: expect 0x00 -> SEND_EN.
  - SEND_EN 6: one-cycle SEND_BYTE, BYTE_TO_SEND=0xF4 -> WAIT_TX_EN.
  - WAIT_TX_EN 7: BYTE_SENT -> WAIT_ACK_EN.
  - WAIT_ACK_EN 8: expect 0xFA -> WAIT_B1.
  - WAIT_B1 9: byte with bit3=1 is latched as status -> WAIT_B2. Byte with bit3=0 is discarded (resync); stay in WAIT_B1.
  - WAIT_B2 10: latch DX -> WAIT_B3.
  - WAIT_B3 11: latch DY -> PUBLISH.
  - PUBLISH 12: MOUSE_STATUS/DX/DY update together from the latched bytes; SEND_INTERRUPT=1 for this cycle only -> WAIT_B1.
- Init response checks (states 3, 4, 5, 8): a wrong value or BYTE_ERROR_CODE!=0 -> IDLE (full restart).
- Streaming byte errors (states 9-11): BYTE_ERROR_CODE!=0 -> discard the partial packet, go to WAIT_B1. MOUSE_* outputs are unchanged.
- Timer:
  - Cleared on every state change; increments otherwise.
  - States 2-5 and 7-8: reaching RESP_TIMEOUT -> IDLE.
  - States 10-11: reaching PKT_TIMEOUT -> WAIT_B1.
  - State 9: no timeout, because an idle mouse sends nothing.
- Simultaneous BYTE_READY and timeout in the same cycle: the byte wins.
- READ_ENABLE: 1 in states 3, 4, 5, 8, 9, 10 and 11; 0 otherwise, including while transmitting.
- BYTE_READY while READ_ENABLE=0 is ignored.
- Latency: SEND_INTERRUPT is asserted 2 cycles after the BYTE_READY of byte 3 (B3 -> PUBLISH, then the output register).
- DX/DY are passed through raw. Sign and overflow bits stay in MOUSE_STATUS; no arithmetic here.

Optional Feature:
Macro MOUSE_PKT_ERR_CNT_EN.
- Defined: adds output PKT_ERR_CNT [7:0], reset 0, saturating at 255. It increments by 1 on each discarded packet:
  - streaming error code;
  - bit3=0 resync;
  - PKT_TIMEOUT.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package mouse_pkg:
  - state encodings 0-12;
  - command constants CMD_RESET=0xFF, CMD_ENABLE=0xF4;
  - response constants RSP_ACK=0xFA, RSP_SELFTEST_OK=0xAA, RSP_ID=0x00.
- One natural sub-module, mouse_resp_timer: a clear/enable counter with a terminal-count compare against a runtime-selected limit (RESP_TIMEOUT or PKT_TIMEOUT).

Test Plan:
- Nominal init: BYTE_SENT after 0xFF; bytes FA, AA, 00; BYTE_SENT after 0xF4; byte FA -> exactly two SEND_BYTE pulses (0xFF, then 0xF4); MASTER_STATE reaches 9.
- Packet: bytes 0x09, 0x05, 0xFB in WAIT_B1 -> 2 cycles after the 3rd BYTE_READY: SEND_INTERRUPT=1 for one cycle; MOUSE_STATUS=0x09, DX=0x05, DY=0xFB.
- Bad self-test: reply 0xFC instead of 0xAA -> back to IDLE, then a new SEND_BYTE with 0xFF.
- Parity error on byte 2 (BYTE_ERROR_CODE=01) -> no interrupt; MOUSE_* unchanged; the next valid 3 bytes publish; PKT_ERR_CNT=1 if MOUSE_PKT_ERR_CNT_EN.
- Timeouts with RESP_TIMEOUT=50, PKT_TIMEOUT=20:
  - no BYTE_SENT for 50 cycles -> IDLE, then 0xFF re-sent;
  - packet stalls after byte 1 for 20 cycles -> WAIT_B1;
  - BYTE_READY coinciding with terminal count -> the byte is accepted.
- RESET asserted during WAIT_B3 -> next cycle all outputs 0, MASTER_STATE=0, then SEND_BYTE with 0xFF two cycles after RESET deasserts.

Source files
------------

// File: rtl/mouse_master_sm_pkg.sv
// Purpose: shared state encodings and PS/2 command/response constants for the
//          mouse bring-up and streaming controller.
// Contents: state_e (debug-visible encodings 0-12), command bytes, expected
//           response bytes, and a helper that marks the receive-enabled states.
package mouse_pkg;

   typedef enum logic [3:0] {
      ST_IDLE          = 4'd0,
      ST_SEND_RST      = 4'd1,
      ST_WAIT_TX_RST   = 4'd2,
      ST_WAIT_ACK_RST  = 4'd3,
      ST_WAIT_SELFTEST = 4'd4,
      ST_WAIT_ID       = 4'd5,
      ST_SEND_EN       = 4'd6,
      ST_WAIT_TX_EN    = 4'd7,
      ST_WAIT_ACK_EN   = 4'd8,
      ST_WAIT_B1       = 4'd9,
      ST_WAIT_B2       = 4'd10,
      ST_WAIT_B3       = 4'd11,
      ST_PUBLISH       = 4'd12
   } state_e;

   localparam logic [7:0] CMD_RESET       = 8'hFF;
   localparam logic [7:0] CMD_ENABLE      = 8'hF4;
   localparam logic [7:0] RSP_ACK         = 8'hFA;
   localparam logic [7:0] RSP_SELFTEST_OK = 8'hAA;
   localparam logic [7:0] RSP_ID          = 8'h00;

   // Bit of packet byte 1 that is always set; used to find packet alignment.
   localparam int unsigned STATUS_SYNC_BIT = 3;

   // States in which the receiver may detect start bits.
   function automatic logic is_rx_state(input state_e s);
      return s inside {ST_WAIT_ACK_RST, ST_WAIT_SELFTEST, ST_WAIT_ID,
                       ST_WAIT_ACK_EN, ST_WAIT_B1, ST_WAIT_B2, ST_WAIT_B3};
   endfunction

endpackage

// File: rtl/mouse_master_sm_if.sv
// Purpose: transmitter/receiver handshake bundle between the mouse controller
//          and the PS/2 line interfaces.
// Signals: SEND_BYTE/BYTE_TO_SEND/BYTE_SENT (host-to-mouse transmitter),
//          READ_ENABLE/BYTE_READ/BYTE_ERROR_CODE/BYTE_READY (mouse receiver).
// Modports: master = controller side, slave = transmitter/receiver side.
interface mouse_master_sm_if;

   logic       SEND_BYTE;
   logic [7:0] BYTE_TO_SEND;
   logic       BYTE_SENT;
   logic       READ_ENABLE;
   logic [7:0] BYTE_READ;
   logic [1:0] BYTE_ERROR_CODE;
   logic       BYTE_READY;

   modport master (
      output SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
      input  BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
   );

   modport slave (
      input  SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
      output BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
   );

endinterface

// File: rtl/mouse_master_sm_resp_timer.sv
// Purpose: clear/enable cycle counter with a terminal-count compare against a
//          runtime-selected limit.
// Ports: CLK, RESET (sync, active high), clr (zero the count), en (count and
//        allow terminal count), limit (terminal value), tc_c (count >= limit).
module mouse_resp_timer #(
   parameter int unsigned W = 26
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic         tc_c
);

   logic [W-1:0] cnt_q;

   // Saturating count so long idle periods never wrap back below the limit.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en && (cnt_q != {W{1'b1}})) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign tc_c = en && (cnt_q >= limit);

endmodule

// File: rtl/mouse_master_sm.sv
// Purpose: PS/2 mouse bring-up (reset, self-test, ID, enable reporting) and
//          3-byte movement packet streaming controller.
// Ports: CLK, RESET (sync, active high), bus (mouse_master_sm_if.master:
//        transmitter and receiver handshakes), MOUSE_STATUS/MOUSE_DX/MOUSE_DY
//        (last packet), SEND_INTERRUPT (one-cycle new-packet pulse),
//        MASTER_STATE (state encoding, debug).
// Option: MOUSE_PKT_ERR_CNT_EN adds PKT_ERR_CNT, a saturating count of
//         discarded packets.
module mouse_master_sm
   import mouse_pkg::*;
#(
   parameter int unsigned RESP_TIMEOUT = 50000000,
   parameter int unsigned PKT_TIMEOUT  = 100000
) (
   input  logic       CLK,
   input  logic       RESET,
   mouse_master_sm_if.master bus,
   output logic [7:0] MOUSE_STATUS,
   output logic [7:0] MOUSE_DX,
   output logic [7:0] MOUSE_DY,
   output logic       SEND_INTERRUPT,
`ifdef MOUSE_PKT_ERR_CNT_EN
   output logic [7:0] PKT_ERR_CNT,
`endif
   output logic [3:0] MASTER_STATE
);

   localparam int unsigned TMAX = (RESP_TIMEOUT > PKT_TIMEOUT) ? RESP_TIMEOUT : PKT_TIMEOUT;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   state_e     state_q, state_d;
   logic       send_byte_q, read_en_q, intr_q;
   logic [7:0] byte_to_send_q;
   logic [7:0] b1_q, b2_q, b3_q;
   logic [7:0] status_q, dx_q, dy_q;

   logic          rx_c, err_c, tc_c;
   logic          tmr_en_c, pkt_sel_c;
   logic [TW-1:0] limit_c;
   logic          latch_b1_c, latch_b2_c, latch_b3_c, discard_c;

   // Bytes only count while the receiver is actually enabled.
   assign rx_c  = bus.BYTE_READY && read_en_q;
   assign err_c = |bus.BYTE_ERROR_CODE;

   assign limit_c = pkt_sel_c ? TW'(PKT_TIMEOUT) : TW'(RESP_TIMEOUT);

   mouse_resp_timer #(.W(TW)) u_timer (
      .CLK   (CLK),
      .RESET (RESET),
      .clr   (state_d != state_q),
      .en    (tmr_en_c),
      .limit (limit_c),
      .tc_c  (tc_c)
   );

   // State register.
   always_ff @(posedge CLK) begin
      if (RESET) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state; a received byte is tested before the timeout so it wins a tie.
   always_comb begin
      state_d    = state_q;
      latch_b1_c = 1'b0;
      latch_b2_c = 1'b0;
      latch_b3_c = 1'b0;
      discard_c  = 1'b0;
      pkt_sel_c  = state_q inside {ST_WAIT_B2, ST_WAIT_B3};
      tmr_en_c   = state_q inside {ST_WAIT_TX_RST, ST_WAIT_ACK_RST, ST_WAIT_SELFTEST,
                                   ST_WAIT_ID, ST_WAIT_TX_EN, ST_WAIT_ACK_EN,
                                   ST_WAIT_B2, ST_WAIT_B3};
      case (state_q)
         ST_IDLE:     state_d = ST_SEND_RST;
         ST_SEND_RST: state_d = ST_WAIT_TX_RST;
         ST_WAIT_TX_RST: begin
            if (bus.BYTE_SENT) state_d = ST_WAIT_ACK_RST;
            else if (tc_c)     state_d = ST_IDLE;
         end
         ST_WAIT_ACK_RST: begin
            if (rx_c)      state_d = (!err_c && bus.BYTE_READ == RSP_ACK) ? ST_WAIT_SELFTEST : ST_IDLE;
            else if (tc_c) state_d = ST_IDLE;
         end
         ST_WAIT_SELFTEST: begin
            if (rx_c)      state_d = (!err_c && bus.BYTE_READ == RSP_SELFTEST_OK) ? ST_WAIT_ID : ST_IDLE;
            else if (tc_c) state_d = ST_IDLE;
         end
         ST_WAIT_ID: begin
            if (rx_c)      state_d = (!err_c && bus.BYTE_READ == RSP_ID) ? ST_SEND_EN : ST_IDLE;
            else if (tc_c) state_d = ST_IDLE;
         end
         ST_SEND_EN: state_d = ST_WAIT_TX_EN;
         ST_WAIT_TX_EN: begin
            if (bus.BYTE_SENT) state_d = ST_WAIT_ACK_EN;
            else if (tc_c)     state_d = ST_IDLE;
         end
         ST_WAIT_ACK_EN: begin
            if (rx_c)      state_d = (!err_c && bus.BYTE_READ == RSP_ACK) ? ST_WAIT_B1 : ST_IDLE;
            else if (tc_c) state_d = ST_IDLE;
         end
         ST_WAIT_B1: begin
            if (rx_c) begin
               if (!err_c && bus.BYTE_READ[STATUS_SYNC_BIT]) begin
                  latch_b1_c = 1'b1;
                  state_d    = ST_WAIT_B2;
               end else begin
                  discard_c = 1'b1;
               end
            end
         end
         ST_WAIT_B2: begin
            if (rx_c) begin
               if (err_c) begin
                  discard_c = 1'b1;
                  state_d   = ST_WAIT_B1;
               end else begin
                  latch_b2_c = 1'b1;
                  state_d    = ST_WAIT_B3;
               end
            end else if (tc_c) begin
               discard_c = 1'b1;
               state_d   = ST_WAIT_B1;
            end
         end
         ST_WAIT_B3: begin
            if (rx_c) begin
               if (err_c) begin
                  discard_c = 1'b1;
                  state_d   = ST_WAIT_B1;
               end else begin
                  latch_b3_c = 1'b1;
                  state_d    = ST_PUBLISH;
               end
            end else if (tc_c) begin
               discard_c = 1'b1;
               state_d   = ST_WAIT_B1;
            end
         end
         ST_PUBLISH: state_d = ST_WAIT_B1;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Output and datapath registers; pulses follow the state by one cycle.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         send_byte_q    <= 1'b0;
         byte_to_send_q <= 8'h00;
         read_en_q      <= 1'b0;
         intr_q         <= 1'b0;
         b1_q           <= 8'h00;
         b2_q           <= 8'h00;
         b3_q           <= 8'h00;
         status_q       <= 8'h00;
         dx_q           <= 8'h00;
         dy_q           <= 8'h00;
      end else begin
         send_byte_q <= (state_q == ST_SEND_RST) || (state_q == ST_SEND_EN);
         if (state_q == ST_SEND_RST)     byte_to_send_q <= CMD_RESET;
         else if (state_q == ST_SEND_EN) byte_to_send_q <= CMD_ENABLE;
         read_en_q <= is_rx_state(state_d);
         intr_q    <= (state_q == ST_PUBLISH);
         if (latch_b1_c) b1_q <= bus.BYTE_READ;
         if (latch_b2_c) b2_q <= bus.BYTE_READ;
         if (latch_b3_c) b3_q <= bus.BYTE_READ;
         if (state_q == ST_PUBLISH) begin
            status_q <= b1_q;
            dx_q     <= b2_q;
            dy_q     <= b3_q;
         end
      end
   end

`ifdef MOUSE_PKT_ERR_CNT_EN
   logic [7:0] err_cnt_q;

   // Discarded-packet counter, saturating.
   always_ff @(posedge CLK) begin
      if (RESET)                               err_cnt_q <= 8'h00;
      else if (discard_c && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
   end

   assign PKT_ERR_CNT = err_cnt_q;
`endif

   assign bus.SEND_BYTE    = send_byte_q;
   assign bus.BYTE_TO_SEND = byte_to_send_q;
   assign bus.READ_ENABLE  = read_en_q;
   assign MOUSE_STATUS     = status_q;
   assign MOUSE_DX         = dx_q;
   assign MOUSE_DY         = dy_q;
   assign SEND_INTERRUPT   = intr_q;
   assign MASTER_STATE     = 4'(state_q);

endmodule

// File: tb/tb_mouse_master_sm.sv
// Bench for mouse_master_sm: directed init/error/timeout/reset scenarios plus a
// randomized packet stream scored against a last-good-packet model.
module tb_mouse_master_sm;

   localparam int unsigned RT = 50;
   localparam int unsigned PT = 20;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [7:0] MOUSE_STATUS, MOUSE_DX, MOUSE_DY;
   logic       SEND_INTERRUPT;
   logic [3:0] MASTER_STATE;
`ifdef MOUSE_PKT_ERR_CNT_EN
   logic [7:0] PKT_ERR_CNT;
`endif

   mouse_master_sm_if bus ();

   mouse_master_sm #(.RESP_TIMEOUT(RT), .PKT_TIMEOUT(PT)) dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .bus            (bus),
      .MOUSE_STATUS   (MOUSE_STATUS),
      .MOUSE_DX       (MOUSE_DX),
      .MOUSE_DY       (MOUSE_DY),
      .SEND_INTERRUPT (SEND_INTERRUPT),
`ifdef MOUSE_PKT_ERR_CNT_EN
      .PKT_ERR_CNT    (PKT_ERR_CNT),
`endif
      .MASTER_STATE   (MASTER_STATE)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;
   int send_cnt = 0;
   int intr_cnt = 0;

   // Reference model: the last successfully received packet and event counts.
   logic [7:0] exp_st = 8'h00, exp_dx = 8'h00, exp_dy = 8'h00;
   int         exp_intr = 0;
   int         exp_err  = 0;

   always @(posedge CLK) begin
      if (bus.SEND_BYTE === 1'b1) send_cnt++;
      if (SEND_INTERRUPT === 1'b1) intr_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_status"}, 32'(MOUSE_STATUS), 32'(exp_st));
      check({tag, "_dx"}, 32'(MOUSE_DX), 32'(exp_dx));
      check({tag, "_dy"}, 32'(MOUSE_DY), 32'(exp_dy));
      check({tag, "_intr_count"}, 32'(intr_cnt), 32'(exp_intr));
`ifdef MOUSE_PKT_ERR_CNT_EN
      check({tag, "_err_cnt"}, 32'(PKT_ERR_CNT), 32'(exp_err > 255 ? 255 : exp_err));
`endif
   endtask

   task automatic wait_send(input string tag, input logic [7:0] exp_b);
      int n = 0;
      while (bus.SEND_BYTE !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check({tag, "_seen"}, 32'(bus.SEND_BYTE), 32'd1);
      check({tag, "_byte"}, 32'(bus.BYTE_TO_SEND), 32'(exp_b));
   endtask

   // Called while SEND_BYTE is high: checks it drops, then acknowledges.
   task automatic tx_done();
      tick();
      check("send_pulse_width", 32'(bus.SEND_BYTE), 32'd0);
      tick();
      bus.BYTE_SENT = 1'b1;
      tick();
      bus.BYTE_SENT = 1'b0;
   endtask

   task automatic rx(input logic [7:0] b, input logic [1:0] e);
      int n = 0;
      while (bus.READ_ENABLE !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) check("rx_read_enable_wait", 32'(bus.READ_ENABLE), 32'd1);
      bus.BYTE_READ       = b;
      bus.BYTE_ERROR_CODE = e;
      bus.BYTE_READY      = 1'b1;
      tick();
      bus.BYTE_READY      = 1'b0;
      bus.BYTE_ERROR_CODE = 2'b00;
   endtask

   task automatic init_from_sent();
      tx_done();
      rx(8'hFA, 2'b00);
      rx(8'hAA, 2'b00);
      rx(8'h00, 2'b00);
      wait_send("send_enable", 8'hF4);
      tx_done();
      rx(8'hFA, 2'b00);
      check("init_state", 32'(MASTER_STATE), 32'd9);
   endtask

   // Third byte has just been accepted: interrupt appears one cycle later.
   task automatic publish_check(input logic [7:0] s, input logic [7:0] dx, input logic [7:0] dy);
      check("pub_intr_early", 32'(SEND_INTERRUPT), 32'd0);
      tick();
      exp_st = s; exp_dx = dx; exp_dy = dy; exp_intr++;
      check("pub_intr", 32'(SEND_INTERRUPT), 32'd1);
      check("pub_status", 32'(MOUSE_STATUS), 32'(s));
      check("pub_dx", 32'(MOUSE_DX), 32'(dx));
      check("pub_dy", 32'(MOUSE_DY), 32'(dy));
      tick();
      check("pub_intr_clear", 32'(SEND_INTERRUPT), 32'd0);
   endtask

   task automatic pkt(input logic [7:0] s, input logic [7:0] dx, input logic [7:0] dy);
      rx(s, 2'b00);
      rx(dx, 2'b00);
      rx(dy, 2'b00);
      publish_check(s, dx, dy);
   endtask

   function automatic logic [7:0] rnd_status();
      return 8'($urandom) | 8'h08;
   endfunction

   initial begin
      logic [7:0] s, dx, dy;
      int base, n, kind;

      RESET = 1'b1;
      bus.BYTE_SENT = 1'b0;
      bus.BYTE_READ = 8'h00;
      bus.BYTE_ERROR_CODE = 2'b00;
      bus.BYTE_READY = 1'b0;
      repeat (3) tick();
      check("rst_state", 32'(MASTER_STATE), 32'd0);
      check("rst_send", 32'(bus.SEND_BYTE), 32'd0);
      check("rst_byte", 32'(bus.BYTE_TO_SEND), 32'd0);
      check("rst_read_en", 32'(bus.READ_ENABLE), 32'd0);
      check("rst_intr", 32'(SEND_INTERRUPT), 32'd0);
      check_outputs("rst");
      RESET = 1'b0;

      // Nominal bring-up: exactly two command transmissions.
      base = send_cnt;
      wait_send("send_reset", 8'hFF);
      init_from_sent();
      check("init_send_count", 32'(send_cnt - base), 32'd2);

      pkt(8'h09, 8'h05, 8'hFB);

      // Parity error on byte 2 drops the packet.
      rx(8'h19, 2'b00);
      rx(8'h33, 2'b01);
      exp_err++;
      check("parity_state", 32'(MASTER_STATE), 32'd9);
      tick();
      check_outputs("parity");
      pkt(8'h28, 8'h7F, 8'h80);

      // Misaligned first byte is discarded.
      rx(8'h07, 2'b00);
      exp_err++;
      check("resync_state", 32'(MASTER_STATE), 32'd9);

      // Stall after byte 1: still waiting at the limit, gone one cycle later.
      rx(8'h18, 2'b00);
      check("pkt_to_enter", 32'(MASTER_STATE), 32'd10);
      repeat (PT) tick();
      check("pkt_to_edge", 32'(MASTER_STATE), 32'd10);
      tick();
      exp_err++;
      check("pkt_to_fire", 32'(MASTER_STATE), 32'd9);
      check_outputs("pkt_to");

      // Byte arriving on the terminal-count cycle is taken.
      rx(8'h3C, 2'b00);
      repeat (PT) tick();
      rx(8'h11, 2'b00);
      check("tc_tie_state", 32'(MASTER_STATE), 32'd11);
      rx(8'h22, 2'b00);
      publish_check(8'h3C, 8'h11, 8'h22);

      // Randomized stream.
      for (int i = 0; i < 40; i++) begin
         kind = int'($urandom_range(0, 5));
         s = rnd_status(); dx = 8'($urandom); dy = 8'($urandom);
         case (kind)
            0, 1: pkt(s, dx, dy);
            2: begin
               rx(s, 2'b00);
               if ($urandom_range(0, 1) == 0) rx(dx, 2'($urandom_range(1, 3)));
               else begin rx(dx, 2'b00); rx(dy, 2'($urandom_range(1, 3))); end
               exp_err++;
            end
            3: begin rx(8'($urandom) & 8'hF7, 2'b00); exp_err++; end
            4: begin rx(s, 2'b00); repeat (PT + 1) tick(); exp_err++; end
            default: begin rx(s, 2'b00); rx(dx, 2'b00); repeat (PT + 1) tick(); exp_err++; end
         endcase
         check("rand_state", 32'(MASTER_STATE), 32'd9);
         tick();
         check_outputs("rand");
      end

      // Reset in WAIT_B3 clears everything and restarts with 0xFF.
      rx(8'h08, 2'b00);
      rx(8'h44, 2'b00);
      check("rst_mid_pre", 32'(MASTER_STATE), 32'd11);
      RESET = 1'b1;
      tick();
      exp_st = 8'h00; exp_dx = 8'h00; exp_dy = 8'h00; exp_err = 0;
      check("rst_mid_state", 32'(MASTER_STATE), 32'd0);
      check("rst_mid_send", 32'(bus.SEND_BYTE), 32'd0);
      check("rst_mid_byte", 32'(bus.BYTE_TO_SEND), 32'd0);
      check("rst_mid_read_en", 32'(bus.READ_ENABLE), 32'd0);
      check_outputs("rst_mid");
      RESET = 1'b0;
      n = 0;
      while (bus.SEND_BYTE !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("rst_restart_delay", 32'(n), 32'd2);
      check("rst_restart_byte", 32'(bus.BYTE_TO_SEND), 32'hFF);

      // No BYTE_SENT: transmit timeout returns to IDLE and resends 0xFF.
      repeat (RT) tick();
      check("tx_to_edge", 32'(MASTER_STATE), 32'd2);
      tick();
      check("tx_to_fire", 32'(MASTER_STATE), 32'd0);
      wait_send("tx_to_resend", 8'hFF);

      // Bad self-test result forces a full restart.
      tx_done();
      rx(8'hFA, 2'b00);
      rx(8'hFC, 2'b00);
      check("bad_selftest_state", 32'(MASTER_STATE), 32'd0);
      wait_send("bad_selftest_resend", 8'hFF);
      init_from_sent();
      pkt(8'h0F, 8'h80, 8'h7F);
      tick();
      check_outputs("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
